// File: rtl/wb_pkg.sv
// wb_pkg: result-select and load-mode encodings shared by the writeback stage
package wb_pkg;
  localparam logic [1:0] WB_SEL_ALU   = 2'd0;
  localparam logic [1:0] WB_SEL_MEM   = 2'd1;
  localparam logic [1:0] WB_SEL_LINK  = 2'd2;
  localparam logic [1:0] WB_SEL_IMM   = 2'd3;
  localparam logic [1:0] LD_WORD      = 2'd0;
  localparam logic [1:0] LD_BYTE_ZX   = 2'd1;
  localparam logic [1:0] LD_BYTE_SX   = 2'd2;
  localparam logic [1:0] LD_HIGH_BYTE = 2'd3;
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: aligns and extends memory read data according to load mode
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] out
);
  logic [DATA_W-1:0] zx, sx, hb;
  always_comb begin
    zx       = '0;
    zx[7:0]  = data[7:0];
    sx       = {DATA_W{data[7]}};
    sx[7:0]  = data[7:0];
    hb       = '0;
    hb[7:0]  = data[DATA_W-1 -: 8];
  end
  assign out = mode == LD_BYTE_ZX ? zx :
               mode == LD_BYTE_SX ? sx :
               mode == LD_HIGH_BYTE ? hb : data;
endmodule

// File: rtl/wb_stage_param.sv
// wb_stage_param: MEM/WB register, result select, regfile/forward drive, sticky halt/error and retire counter
module wb_stage_param
  import wb_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [DATA_W-1:0]     in_link,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic [1:0]            in_wb_sel,
  input  logic [1:0]            in_load_mode,
  input  logic [REG_ADDR_W-1:0] in_wr_reg,
  input  logic                  in_wr_en,
  input  logic                  in_halt,
  input  logic                  in_err,
  output logic                  wb_valid,
  output logic [DATA_W-1:0]     wr_data,
  output logic [REG_ADDR_W-1:0] wr_reg,
  output logic                  wr_en,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  halted,
  output logic                  err_out,
  output logic [CNT_W-1:0]      retire_count
);
  logic                  valid_q, valid_d, fresh_q, fresh_d;
  logic [DATA_W-1:0]     alu_q, alu_d, mem_q, mem_d, link_q, link_d, imm_q, imm_d;
  logic [1:0]            sel_q, sel_d, mode_q, mode_d;
  logic [REG_ADDR_W-1:0] reg_q, reg_d;
  logic                  wen_q, wen_d, halt_q, halt_d, err_q, err_d;
  logic                  halted_q, halted_d, err_out_q, err_out_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  set_halt, load;
  logic [DATA_W-1:0]     ld_data;
  wb_load_align #(.DATA_W(DATA_W)) u_align (.data(mem_q), .mode(mode_q), .out(ld_data));
  always_comb begin
    set_halt  = valid_q & (halt_q | err_q);
    halted_d  = halted_q | set_halt;
    err_out_d = err_out_q | (valid_q & err_q);
    cnt_d     = (valid_q & fresh_q & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    load      = ~flush & ~stall & ~halted_d;
    valid_d   = flush ? 1'b0 : stall ? valid_q : load & in_valid;
    fresh_d   = load & in_valid;
    alu_d     = load ? in_alu_result : alu_q;
    mem_d     = load ? in_mem_data : mem_q;
    link_d    = load ? in_link : link_q;
    imm_d     = load ? in_imm : imm_q;
    sel_d     = load ? in_wb_sel : sel_q;
    mode_d    = load ? in_load_mode : mode_q;
    reg_d     = load ? in_wr_reg : reg_q;
    wen_d     = load ? in_wr_en : wen_q;
    halt_d    = load ? in_halt : halt_q;
    err_d     = load ? in_err : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      fresh_q   <= 1'b0;
      alu_q     <= '0;
      mem_q     <= '0;
      link_q    <= '0;
      imm_q     <= '0;
      sel_q     <= '0;
      mode_q    <= '0;
      reg_q     <= '0;
      wen_q     <= 1'b0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
      halted_q  <= 1'b0;
      err_out_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      fresh_q   <= fresh_d;
      alu_q     <= alu_d;
      mem_q     <= mem_d;
      link_q    <= link_d;
      imm_q     <= imm_d;
      sel_q     <= sel_d;
      mode_q    <= mode_d;
      reg_q     <= reg_d;
      wen_q     <= wen_d;
      halt_q    <= halt_d;
      err_q     <= err_d;
      halted_q  <= halted_d;
      err_out_q <= err_out_d;
      cnt_q     <= cnt_d;
    end
  end
  assign wb_valid     = valid_q;
  assign wr_en        = valid_q & wen_q & ~halt_q & ~err_q & ~halted_q;
  assign wr_reg       = reg_q;
  assign wr_data      = sel_q == WB_SEL_ALU ? alu_q :
                        sel_q == WB_SEL_MEM ? ld_data :
                        sel_q == WB_SEL_LINK ? link_q : imm_q;
  assign fwd_valid    = wr_en;
  assign fwd_reg      = wr_reg;
  assign fwd_data     = wr_data;
  assign halted       = halted_q;
  assign err_out      = err_out_q;
  assign retire_count = cnt_q;
endmodule

// File: tb/tb_wb_stage_param.sv
// tb_wb_stage_param: directed stimulus with a behavioural reference model and literal checkpoints
module tb_wb_stage_param;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, stall = 0, flush = 0;
  logic [15:0] in_alu_result = 0, in_mem_data = 0, in_link = 0, in_imm = 0;
  logic [1:0]  in_wb_sel = 0, in_load_mode = 0;
  logic [2:0]  in_wr_reg = 0;
  logic        in_wr_en = 0, in_halt = 0, in_err = 0;
  logic        wb_valid, wr_en, fwd_valid, halted, err_out;
  logic [15:0] wr_data, fwd_data;
  logic [2:0]  wr_reg, fwd_reg;
  logic [CNT_W-1:0] retire_count;
  int n_chk = 0, n_fail = 0;
  wb_stage_param #(.DATA_W(16), .REG_ADDR_W(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_link(in_link),
    .in_imm(in_imm), .in_wb_sel(in_wb_sel), .in_load_mode(in_load_mode),
    .in_wr_reg(in_wr_reg), .in_wr_en(in_wr_en), .in_halt(in_halt), .in_err(in_err),
    .wb_valid(wb_valid), .wr_data(wr_data), .wr_reg(wr_reg), .wr_en(wr_en),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .halted(halted), .err_out(err_out), .retire_count(retire_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: entry captured into WB plus sticky state and a plain integer count
  logic        armed = 0;
  logic        m_v = 0, m_f = 0, m_h = 0, m_e = 0;
  int          m_cnt = 0;
  logic [15:0] m_alu = 0, m_mem = 0, m_link = 0, m_imm = 0;
  logic [1:0]  m_sel = 0, m_mode = 0;
  logic [2:0]  m_reg = 0;
  logic        m_wen = 0, m_halt = 0, m_err = 0;
  function automatic int result(input logic [1:0] sel, input logic [1:0] mode,
                                input int alu, input int mem, input int link, input int imm);
    int lo;
    lo = mem % 256;
    if (sel == 0) return alu;
    if (sel == 2) return link;
    if (sel == 3) return imm;
    if (mode == 1) return lo;
    if (mode == 2) return lo >= 128 ? lo + 'hFF00 : lo;
    if (mode == 3) return mem / 256;
    return mem;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      armed <= 1; m_v <= 0; m_f <= 0; m_h <= 0; m_e <= 0; m_cnt <= 0;
    end else begin
      if (m_v && m_f && m_cnt < CMAX) m_cnt <= m_cnt + 1;
      if (m_v && (m_halt || m_err)) m_h <= 1;
      if (m_v && m_err) m_e <= 1;
      m_f <= 0;
      if (flush) m_v <= 0;
      else if (!stall) begin
        if (m_h || (m_v && (m_halt || m_err))) m_v <= 0;
        else begin
          m_v <= in_valid; m_f <= in_valid;
          m_alu <= in_alu_result; m_mem <= in_mem_data; m_link <= in_link; m_imm <= in_imm;
          m_sel <= in_wb_sel; m_mode <= in_load_mode; m_reg <= in_wr_reg;
          m_wen <= in_wr_en; m_halt <= in_halt; m_err <= in_err;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      automatic logic ew = m_v && m_wen && !m_halt && !m_err && !m_h;
      automatic logic [15:0] ed = 16'(result(m_sel, m_mode, m_alu, m_mem, m_link, m_imm));
      chk("m_valid", 32'(wb_valid), 32'(m_v));
      chk("m_wr_en", 32'(wr_en), 32'(ew));
      chk("m_fwd_valid", 32'(fwd_valid), 32'(ew));
      chk("m_halted", 32'(halted), 32'(m_h));
      chk("m_err", 32'(err_out), 32'(m_e));
      chk("m_count", 32'(retire_count), 32'(m_cnt));
      if (m_v) begin
        chk("m_wr_data", 32'(wr_data), 32'(ed));
        chk("m_wr_reg", 32'(wr_reg), 32'(m_reg));
        chk("m_fwd_data", 32'(fwd_data), 32'(ed));
        chk("m_fwd_reg", 32'(fwd_reg), 32'(m_reg));
      end
    end
  end
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic entry(input logic v, input logic [1:0] sel, input logic [1:0] mode,
                       input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] link,
                       input logic [2:0] r, input logic we, input logic h, input logic e);
    in_valid = v; in_wb_sel = sel; in_load_mode = mode; in_alu_result = alu;
    in_mem_data = mem; in_link = link; in_imm = 16'h5A5A; in_wr_reg = r;
    in_wr_en = we; in_halt = h; in_err = e;
  endtask
  task automatic idle();
    entry(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    logic [1:0]  modes [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] lexp  [4] = '{16'h00F5, 16'hFFF5, 16'h0080, 16'h80F5};
    cycle(); cycle();
    chk("rst_valid", 32'(wb_valid), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_count", 32'(retire_count), 0);
    rst = 0;
    entry(1, 0, 0, 16'h1234, 0, 0, 3, 1, 0, 0);
    cycle(); idle();
    chk("alu_wr_en", 32'(wr_en), 1);
    chk("alu_wr_reg", 32'(wr_reg), 3);
    chk("alu_wr_data", 32'(wr_data), 32'h1234);
    chk("alu_fwd_valid", 32'(fwd_valid), 1);
    cycle();
    chk("alu_count", 32'(retire_count), 1);
    for (int i = 0; i < 4; i++) begin
      entry(1, 1, modes[i], 0, 16'h80F5, 0, 1, 1, 0, 0);
      cycle();
      chk("load_data", 32'(wr_data), 32'(lexp[i]));
    end
    idle();
    cycle();
    chk("load_count", 32'(retire_count), 5);
    entry(1, 2, 0, 0, 0, 16'h0042, 5, 1, 0, 0);
    cycle();
    chk("stall_data0", 32'(wr_data), 32'h0042);
    stall = 1;
    entry(1, 0, 0, 16'h9999, 0, 0, 6, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_data", 32'(wr_data), 32'h0042);
      chk("stall_wr_en", 32'(wr_en), 1);
    end
    stall = 0; idle();
    cycle();
    chk("stall_count", 32'(retire_count), 6);
    entry(1, 0, 0, 16'h4444, 0, 0, 4, 1, 0, 0);
    flush = 1; stall = 1;
    cycle();
    flush = 0; stall = 0; idle();
    chk("flush_valid", 32'(wb_valid), 0);
    chk("flush_wr_en", 32'(wr_en), 0);
    cycle();
    chk("flush_count", 32'(retire_count), 6);
    entry(1, 0, 0, 16'h7777, 0, 0, 2, 1, 1, 0);
    cycle();
    chk("halt_valid", 32'(wb_valid), 1);
    chk("halt_wr_en", 32'(wr_en), 0);
    chk("halt_pre", 32'(halted), 0);
    entry(1, 0, 0, 16'h1111, 0, 0, 1, 1, 0, 0);
    cycle();
    chk("halt_set", 32'(halted), 1);
    chk("halt_discard", 32'(wb_valid), 0);
    cycle();
    chk("halt_frozen", 32'(wb_valid), 0);
    chk("halt_count", 32'(retire_count), 7);
    chk("halt_no_err", 32'(err_out), 0);
    rst = 1; idle(); cycle(); rst = 0;
    entry(1, 0, 0, 16'h2222, 0, 0, 1, 1, 0, 1);
    cycle(); idle();
    chk("err_wr_en", 32'(wr_en), 0);
    cycle();
    chk("err_halted", 32'(halted), 1);
    chk("err_out", 32'(err_out), 1);
    rst = 1; cycle(); rst = 0;
    chk("rst2_halted", 32'(halted), 0);
    chk("rst2_err", 32'(err_out), 0);
    chk("rst2_valid", 32'(wb_valid), 0);
    chk("rst2_data", 32'(wr_data), 0);
    chk("rst2_fwd", 32'(fwd_valid), 0);
    chk("rst2_count", 32'(retire_count), 0);
    entry(1, 0, 0, 16'hBEEF, 0, 0, 7, 1, 0, 0);
    cycle(); idle();
    chk("beef_wr_en", 32'(wr_en), 1);
    chk("beef_reg", 32'(wr_reg), 7);
    chk("beef_data", 32'(wr_data), 32'hBEEF);
    rst = 1; cycle(); rst = 0;
    for (int i = 0; i < 20; i++) begin
      entry(1, 3, 0, 0, 0, 0, 3'(i), 1, 0, 0);
      cycle();
    end
    idle(); cycle(); cycle();
    chk("sat_count", 32'(retire_count), 32'hF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
